// File: rtl/video_pkg.sv
// video_pkg: shared video timing defaults and the frame-reader state encoding.
package video_pkg;
  localparam int HDISP = 800;
  localparam int VDISP = 480;
  typedef enum logic [1:0] {IDLE, READ, PAUSE} rd_state_e;
endpackage

// File: rtl/wshb_frame_reader_sync_edge.sv
// sync_edge: 2-FF synchroniser for a pixel-domain level plus a rising-edge pulse in the sys domain.
module sync_edge (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic async_i,
  output logic rise_o
);
  logic [2:0] sync_q;
  always_ff @(posedge sys_clk or posedge sys_rst)
    if (sys_rst) sync_q <= '0;
    else sync_q <= {sync_q[1:0], async_i};
  assign rise_o = sync_q[1] & ~sync_q[2];
endmodule

// File: rtl/wshb_frame_reader.sv
// wshb_frame_reader: Wishbone master streaming one frame of pixels from SDRAM into the video FIFO per vsync.
module wshb_frame_reader
  import video_pkg::*;
#(
  parameter int          HDISP     = video_pkg::HDISP,
  parameter int          VDISP     = video_pkg::VDISP,
  parameter logic [31:0] BASE_ADR  = 32'h0,
  parameter int          BURST_MAX = 64
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  output logic        wshb_cyc_o,
  output logic        wshb_stb_o,
  output logic        wshb_we_o,
  output logic [31:0] wshb_adr_o,
  output logic [31:0] wshb_dat_ms_o,
  output logic [3:0]  wshb_sel_o,
  output logic [2:0]  wshb_cti_o,
  output logic [1:0]  wshb_bte_o,
  input  logic [31:0] wshb_dat_sm_i,
  input  logic        wshb_ack_i,
  input  logic        wshb_err_i,
  input  logic        wshb_rty_i,
  input  logic        vs_async_i,
  input  logic        fifo_almost_full_i,
  output logic        fifo_write_o,
  output logic [31:0] fifo_wdata_o,
  output logic        frame_done_o,
  output logic        busy_o
);
  localparam int NPIX = HDISP * VDISP;
  localparam int PW   = NPIX > 1 ? $clog2(NPIX) : 1;
  localparam int BW   = $clog2(BURST_MAX + 1);
  rd_state_e     state_q;
  logic [PW-1:0] pix_cnt_q;
  logic [BW-1:0] burst_cnt_q;
  logic          fifo_write_q, last_q, frame_done_q;
  logic [31:0]   fifo_wdata_q;
  logic          frame_start, acc, last_pix;
  sync_edge u_vs_sync (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .async_i (vs_async_i),
    .rise_o  (frame_start)
  );
  assign acc      = (state_q == READ) && wshb_ack_i;
  assign last_pix = pix_cnt_q == PW'(NPIX - 1);
  // A vsync landing on the last ack is not an overrun: finish the frame and chain straight into the next.
  always_ff @(posedge sys_clk or posedge sys_rst)
    if (sys_rst) begin
      state_q      <= IDLE;
      pix_cnt_q    <= '0;
      burst_cnt_q  <= '0;
      fifo_write_q <= 1'b0;
      fifo_wdata_q <= '0;
      last_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      fifo_write_q <= acc;
      if (acc) fifo_wdata_q <= wshb_dat_sm_i;
      last_q       <= acc && last_pix;
      frame_done_q <= last_q;
      case (state_q)
        IDLE:
          if (frame_start) begin
            state_q     <= READ;
            pix_cnt_q   <= '0;
            burst_cnt_q <= '0;
          end
        READ:
          if (acc && last_pix) begin
            state_q     <= frame_start ? READ : IDLE;
            pix_cnt_q   <= '0;
            burst_cnt_q <= '0;
          end else if (frame_start) begin
            state_q     <= PAUSE;
            pix_cnt_q   <= '0;
            burst_cnt_q <= '0;
          end else if (acc) begin
            pix_cnt_q   <= pix_cnt_q + 1'b1;
            burst_cnt_q <= burst_cnt_q + 1'b1;
            if (fifo_almost_full_i || burst_cnt_q == BW'(BURST_MAX - 1)) state_q <= PAUSE;
          end else if (wshb_err_i || wshb_rty_i || fifo_almost_full_i) state_q <= PAUSE;
        PAUSE: begin
          burst_cnt_q <= '0;
          if (frame_start) pix_cnt_q <= '0;
          else if (!fifo_almost_full_i) state_q <= READ;
        end
        default: state_q <= IDLE;
      endcase
    end
  assign wshb_cyc_o    = state_q == READ;
  assign wshb_stb_o    = state_q == READ;
  assign wshb_we_o     = 1'b0;
  assign wshb_sel_o    = 4'hF;
  assign wshb_cti_o    = 3'b000;
  assign wshb_bte_o    = 2'b00;
  assign wshb_dat_ms_o = '0;
  assign wshb_adr_o    = BASE_ADR + (32'(pix_cnt_q) << 2);
  assign fifo_write_o  = fifo_write_q;
  assign fifo_wdata_o  = fifo_wdata_q;
  assign frame_done_o  = frame_done_q;
  assign busy_o        = state_q != IDLE;
endmodule

// File: tb/tb_wshb_frame_reader.sv
// tb_wshb_frame_reader: randomized Wishbone slave and FIFO against a frame-level reference of the reader.
module tb_wshb_frame_reader;
  localparam int          NPIX = 8;
  localparam logic [31:0] BASE = 32'h0;
  logic        sys_clk = 1'b0, sys_rst;
  logic        cyc, stb, we, ack, err, rty, vs, afull, fw, fd, busy;
  logic [31:0] adr, dat_ms, dat_sm, fwd;
  logic [3:0]  sel;
  logic [2:0]  cti;
  logic [1:0]  bte;
  int n_chk = 0, n_pass = 0;
  logic [31:0] wq[$], aq[$];
  int done_cnt, nack, stb_ticks, pause_ticks, af_wr, gcnt;
  int ack_pct = 100, err_pct = 0, af_pct = 0, ack_div = 1;
  int af_at_ack = -1, vs_at_ack = -1, vs_cnt = 0, af_cnt = 0;
  logic        err_armed = 1'b0;
  logic [31:0] err_adr = '0;
  logic        p_ack = 0, p_err = 0, p_stb = 0, p_afull = 0, p_wr = 0;
  logic [31:0] p_dat = '0, p_adr = '0, p_wdata = '0;

  always #5 sys_clk = ~sys_clk;

  wshb_frame_reader #(.HDISP(4), .VDISP(2), .BASE_ADR(BASE), .BURST_MAX(4)) dut (
    .sys_clk            (sys_clk),
    .sys_rst            (sys_rst),
    .wshb_cyc_o         (cyc),
    .wshb_stb_o         (stb),
    .wshb_we_o          (we),
    .wshb_adr_o         (adr),
    .wshb_dat_ms_o      (dat_ms),
    .wshb_sel_o         (sel),
    .wshb_cti_o         (cti),
    .wshb_bte_o         (bte),
    .wshb_dat_sm_i      (dat_sm),
    .wshb_ack_i         (ack),
    .wshb_err_i         (err),
    .wshb_rty_i         (rty),
    .vs_async_i         (vs),
    .fifo_almost_full_i (afull),
    .fifo_write_o       (fw),
    .fifo_wdata_o       (fwd),
    .frame_done_o       (fd),
    .busy_o             (busy)
  );

  function automatic logic [31:0] fdat(logic [31:0] a);
    return a * 32'h0101_0101 + 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] padr(int i);
    return BASE + 32'(i) * 32'd4;
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // One sys_clk cycle: observe outputs at negedge, then drive the slave and FIFO for the next edge.
  task automatic tick();
    bit go;
    @(negedge sys_clk);
    if (!sys_rst) begin
      chk("fifo_write", 32'(fw), 32'(p_ack));
      if (p_ack) chk("fifo_wdata", fwd, p_dat);
      chk("frame_done", 32'(fd), 32'(p_wr && p_wdata == fdat(padr(NPIX - 1))));
      chk("cyc_eq_stb", 32'(cyc), 32'(stb));
      if (stb) chk("static_out", {20'h0, we, sel, cti, bte, 2'b00}, {20'h0, 1'b0, 4'hF, 3'b000, 2'b00, 2'b00});
      if (p_stb && !p_ack && !p_err && stb) chk("adr_hold", adr, p_adr);
      if (p_stb && p_afull) chk("afull_drop", 32'(stb), 32'd0);
      if (fw && afull) af_wr++;
    end
    if (fw) wq.push_back(fwd);
    if (fd) done_cnt++;
    if (stb) stb_ticks++;
    if (busy && !stb) pause_ticks++;
    ack = 1'b0; err = 1'b0; rty = 1'b0; dat_sm = $urandom;
    if (stb && !sys_rst) begin
      go = (gcnt % ack_div) == 0;
      gcnt++;
      if (err_armed && adr == err_adr) begin
        err = 1'b1;
        err_armed = 1'b0;
      end else if ($urandom_range(0, 99) < err_pct) begin
        if ($urandom_range(0, 1) == 1) err = 1'b1;
        else rty = 1'b1;
      end else if (go && $urandom_range(0, 99) < ack_pct) begin
        ack = 1'b1;
        dat_sm = fdat(adr);
        aq.push_back(adr);
        nack++;
        if (nack == af_at_ack) af_cnt = 10;
        if (nack == vs_at_ack) vs_cnt = 6;
      end
    end
    vs = vs_cnt > 0;
    if (vs_cnt > 0) vs_cnt--;
    afull = af_cnt > 0 || $urandom_range(0, 99) < af_pct;
    if (af_cnt > 0) af_cnt--;
    p_ack = ack; p_err = err | rty; p_stb = stb; p_afull = afull;
    p_dat = dat_sm; p_adr = adr; p_wr = fw; p_wdata = fwd;
  endtask

  task automatic idle(int n);
    repeat (n) tick();
  endtask

  task automatic begin_frame();
    wq.delete(); aq.delete();
    done_cnt = 0; nack = 0; stb_ticks = 0; pause_ticks = 0; af_wr = 0; gcnt = 0;
    vs = 1'b1;
    vs_cnt = 5;
  endtask

  task automatic wait_done(string tag, int lim);
    int t = 0;
    while (done_cnt == 0 && t < lim) begin
      tick();
      t++;
    end
    idle(2);
    chk({tag, "_done_count"}, 32'(done_cnt), 32'd1);
  endtask

  // A frame is the pixel sequence 0..NPIX-1; an overrun may leave a strict prefix of the aborted frame before it.
  task automatic check_frame(string tag, bit aborted);
    int k;
    k = wq.size() - NPIX;
    if (aborted) chk({tag, "_abort_prefix"}, 32'(k > 0 && k < NPIX), 32'd1);
    else chk({tag, "_nwords"}, 32'(wq.size()), 32'(NPIX));
    if (k >= 0) begin
      for (int i = 0; i < k; i++) chk($sformatf("%s_old%0d", tag, i), wq[i], fdat(padr(i)));
      for (int i = 0; i < NPIX; i++) chk($sformatf("%s_px%0d", tag, i), wq[k + i], fdat(padr(i)));
    end
  endtask

  task automatic check_addrs(string tag);
    chk({tag, "_nacks"}, 32'(aq.size()), 32'(NPIX));
    if (aq.size() == NPIX)
      for (int i = 0; i < NPIX; i++) chk($sformatf("%s_adr%0d", tag, i), aq[i], padr(i));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, t;
    vs = 1'b0; afull = 1'b0; ack = 1'b0; err = 1'b0; rty = 1'b0; dat_sm = '0;
    sys_rst = 1'b0;
    #1 sys_rst = 1'b1;
    repeat (3) @(negedge sys_clk);
    chk("rst_ctrl", {27'h0, cyc, stb, busy, fw, fd}, 32'h0);
    chk("rst_adr", adr, BASE);
    chk("rst_wdata", fwd, 32'h0);
    chk("rst_dat_ms", dat_ms, 32'h0);
    sys_rst = 1'b0;
    idle(5);
    // Continuous ack: 8 reads in two bursts of 4 separated by one released cycle.
    begin_frame();
    lat = 0;
    while (!stb && lat < 10) begin
      tick();
      lat++;
    end
    chk("vs_to_stb", 32'(lat >= 3 && lat <= 4), 32'd1);
    wait_done("basic", 100);
    check_frame("basic", 1'b0);
    check_addrs("basic");
    chk("burst_gap", 32'(pause_ticks), 32'd1);
    chk("basic_stb_cycles", 32'(stb_ticks), 32'(NPIX));
    chk("basic_idle", 32'(busy), 32'd0);
    idle(10);
    // Almost-full held for 10 cycles after the 3rd ack.
    af_at_ack = 3;
    begin_frame();
    wait_done("afull", 200);
    af_at_ack = -1;
    check_frame("afull", 1'b0);
    check_addrs("afull");
    chk("afull_extra_writes", 32'(af_wr <= 3), 32'd1);
    chk("afull_paused", 32'(pause_ticks >= 9), 32'd1);
    idle(10);
    // Bus error on 0x8: re-read through a pause.
    err_armed = 1'b1;
    err_adr = padr(2);
    begin_frame();
    wait_done("err", 200);
    check_frame("err", 1'b0);
    check_addrs("err");
    chk("err_consumed", 32'(err_armed), 32'd0);
    idle(10);
    // Overrun: a second vsync edge after 5 acks, with a slow slave so the frame cannot finish first.
    ack_div = 3;
    vs_at_ack = 5;
    begin_frame();
    wait_done("abort", 400);
    check_frame("abort", 1'b1);
    vs_at_ack = -1;
    ack_div = 1;
    idle(10);
    // Asynchronous reset in the middle of a read.
    begin_frame();
    t = 0;
    while (nack < 3 && t < 50) begin
      tick();
      t++;
    end
    #2 sys_rst = 1'b1;
    vs_cnt = 0;
    vs = 1'b0;
    ack = 1'b0;
    #1 chk("rst_async", {28'h0, cyc, stb, fw, busy}, 32'h0);
    idle(3);
    sys_rst = 1'b0;
    wq.delete();
    stb_ticks = 0;
    done_cnt = 0;
    idle(20);
    chk("rst_quiet_stb", 32'(stb_ticks), 32'd0);
    chk("rst_quiet_writes", 32'(wq.size()), 32'd0);
    chk("rst_quiet_done", 32'(done_cnt), 32'd0);
    begin_frame();
    wait_done("post_rst", 200);
    check_frame("post_rst", 1'b0);
    check_addrs("post_rst");
    idle(10);
    // Randomized slave latency, errors/retries and FIFO back-pressure.
    for (int f = 0; f < 6; f++) begin
      ack_pct = $urandom_range(30, 100);
      err_pct = $urandom_range(0, 8);
      af_pct  = $urandom_range(0, 20);
      begin_frame();
      wait_done($sformatf("rand%0d", f), 3000);
      check_frame($sformatf("rand%0d", f), 1'b0);
      check_addrs($sformatf("rand%0d", f));
      ack_pct = 100; err_pct = 0; af_pct = 0;
      idle(10);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
